// File: rtl/lot_gate_ctrl_pkg.sv
// Shared definitions for the parking-lot gate controller.
// Contents:
//   gate_state_t     - controller states (IDLE, OPEN_IN, OPEN_OUT, CLOSING)
//   LOT_CAPACITY     - default maximum number of parked cars
//   LOT_CNT_W        - default occupancy count width
//   GATE_TIMEOUT_CYC - default open-gate timeout, in cycles
//   GATE_CLOSE_CYC   - default closed settle interval, in cycles
package lot_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSING  = 2'd3
    } gate_state_t;

    localparam int unsigned LOT_CAPACITY     = 15;
    localparam int unsigned LOT_CNT_W        = 4;
    localparam int unsigned GATE_TIMEOUT_CYC = 1000;
    localparam int unsigned GATE_CLOSE_CYC   = 8;

endpackage

// File: rtl/lot_gate_ctrl_if.sv
// Signal bundle between the lane (buttons, sensor FSM) and the gate controller.
// Signals:
//   entry_req, exit_req  - level requests from the outside / inside buttons
//   enter, exit          - one-cycle passage pulses from the sensor FSM
//   gate_open            - barrier drive
//   dir_in               - 1 = current or last grant was inbound
//   occupancy            - current car count
//   full, empty          - occupancy flags
//   busy                 - controller not idle
//   timeout_err          - one-cycle pulse on an expired open period
// Modports: master = lane side (drives requests/pulses), slave = controller.
interface lot_gate_ctrl_if
    import lot_pkg::*;
#(
    parameter int unsigned CNT_W = LOT_CNT_W
);

    logic             entry_req;
    logic             exit_req;
    logic             enter;
    logic             exit;
    logic             gate_open;
    logic             dir_in;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             busy;
    logic             timeout_err;

    modport master (
        output entry_req, exit_req, enter, exit,
        input  gate_open, dir_in, occupancy, full, empty, busy, timeout_err
    );

    modport slave (
        input  entry_req, exit_req, enter, exit,
        output gate_open, dir_in, occupancy, full, empty, busy, timeout_err
    );

endinterface

// File: rtl/lot_gate_ctrl_occ_counter.sv
// Saturating up/down occupancy counter.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   inc, dec   - count up / down requests; both together leave the count unchanged
//   count      - registered count, saturates at 0 and CAPACITY
//   full       - count == CAPACITY
//   empty      - count == 0
module occ_counter
    import lot_pkg::*;
#(
    parameter int unsigned CAPACITY = LOT_CAPACITY,
    parameter int unsigned CNT_W    = LOT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != CNT_W'(CAPACITY))) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CNT_W'(CAPACITY));
    assign empty = (count_q == '0);

endmodule

// File: rtl/lot_gate_ctrl.sv
// Shared barrier gate sequencer: grants the single lane to an inbound or
// outbound driver (round-robin on contention), holds the gate open until the
// matching passage pulse or a timeout, then holds it closed for a settle
// interval. Occupancy is tracked from the sensor pulses in every state.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - lot_gate_ctrl_if.slave (requests, passage pulses, gate/status outputs)
module lot_gate_ctrl
    import lot_pkg::*;
#(
    parameter int unsigned CAPACITY    = LOT_CAPACITY,
    parameter int unsigned CNT_W       = LOT_CNT_W,
    parameter int unsigned TIMEOUT_CYC = GATE_TIMEOUT_CYC,
    parameter int unsigned CLOSE_CYC   = GATE_CLOSE_CYC
) (
    input  logic           clk,
    input  logic           reset,
    lot_gate_ctrl_if.slave bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
    localparam int unsigned CL_W = $clog2(CLOSE_CYC + 1);

    gate_state_t      state_q, state_d;
    logic             last_in_q, last_in_d;   // last grant was inbound; also drives dir_in
    logic             gate_q, gate_d;
    logic             terr_q, terr_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CL_W-1:0]  cl_q, cl_d;

    logic             elig_in;
    logic             elig_out;
    logic [CNT_W-1:0] occ_w;
    logic             full_w;
    logic             empty_w;

    occ_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occ (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.enter),
        .dec   (bus.exit),
        .count (occ_w),
        .full  (full_w),
        .empty (empty_w)
    );

    always_comb begin
        state_d   = state_q;
        last_in_d = last_in_q;
        terr_d    = 1'b0;
        to_d      = '0;
        cl_d      = '0;
        // Eligibility uses the registered flags, so a passage pulse in the
        // grant cycle never cancels that grant.
        elig_in   = bus.entry_req & ~full_w;
        elig_out  = bus.exit_req & ~empty_w;

        case (state_q)
            IDLE: begin
                // Inbound wins if it is the only request, or on contention
                // when the previous grant was outbound.
                if (elig_in && (!elig_out || !last_in_q)) begin
                    state_d   = OPEN_IN;
                    last_in_d = 1'b1;
                end else if (elig_out) begin
                    state_d   = OPEN_OUT;
                    last_in_d = 1'b0;
                end
            end
            OPEN_IN: begin
                if (bus.enter) begin
                    state_d = CLOSING;
                end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = CLOSING;
                    terr_d  = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            OPEN_OUT: begin
                if (bus.exit) begin
                    state_d = CLOSING;
                end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = CLOSING;
                    terr_d  = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            CLOSING: begin
                if (cl_q == CL_W'(CLOSE_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    cl_d = cl_q + CL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        gate_d = (state_d == OPEN_IN) || (state_d == OPEN_OUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_in_q <= 1'b0;
            gate_q    <= 1'b0;
            terr_q    <= 1'b0;
            to_q      <= '0;
            cl_q      <= '0;
        end else begin
            state_q   <= state_d;
            last_in_q <= last_in_d;
            gate_q    <= gate_d;
            terr_q    <= terr_d;
            to_q      <= to_d;
            cl_q      <= cl_d;
        end
    end

    assign bus.gate_open   = gate_q;
    assign bus.dir_in      = last_in_q;
    assign bus.occupancy   = occ_w;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_lot_gate_ctrl.sv
// Directed bench for lot_gate_ctrl: a per-cycle vector table for entry,
// counter corner cases, wrong-direction pulses and timeout, plus hand-written
// sequences for fill-to-capacity, round-robin and mid-operation reset.
module tb_lot_gate_ctrl;

    logic clk;
    logic reset;

    lot_gate_ctrl_if #(.CNT_W(4)) bus ();

    lot_gate_ctrl #(
        .CAPACITY    (15),
        .CNT_W       (4),
        .TIMEOUT_CYC (1000),
        .CLOSE_CYC   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // One record is applied for reps consecutive cycles; outputs are checked
    // after every one of those clock edges.
    typedef struct {
        int         reps;
        logic       er, xr, en, ex;
        logic       go, di;
        logic [3:0] occ;
        logic       fu, em, bu, te;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int reps,
                                input logic er, input logic xr, input logic en, input logic ex,
                                input logic go, input logic di, input logic [3:0] occ,
                                input logic fu, input logic em, input logic bu, input logic te);
        vec_t v;
        v.reps = reps;
        v.er = er; v.xr = xr; v.en = en; v.ex = ex;
        v.go = go; v.di = di; v.occ = occ;
        v.fu = fu; v.em = em; v.bu = bu; v.te = te;
        return v;
    endfunction

    // {gate_open, dir_in, occupancy[3:0], full, empty, busy, timeout_err}
    function automatic logic [9:0] outs();
        return {bus.gate_open, bus.dir_in, bus.occupancy,
                bus.full, bus.empty, bus.busy, bus.timeout_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic er, input logic xr, input logic en, input logic ex);
        bus.entry_req = er;
        bus.exit_req  = xr;
        bus.enter     = en;
        bus.exit      = ex;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0);
        #12;
        chk("reset_vals", 32'(outs()), 32'(10'b0_0_0000_0_1_0_0));
        @(negedge clk);
        reset = 1'b0;

        // basic entry: grant, gate open 5 cycles, enter, 8-cycle close
        tbl.push_back(mk(1,   1,0,0,0, 1,1,4'd0, 0,1,1,0));
        tbl.push_back(mk(4,   0,0,0,0, 1,1,4'd0, 0,1,1,0));
        tbl.push_back(mk(1,   0,0,1,0, 0,1,4'd1, 0,0,1,0));
        tbl.push_back(mk(7,   0,0,0,0, 0,1,4'd1, 0,0,1,0));
        tbl.push_back(mk(1,   0,0,0,0, 0,1,4'd1, 0,0,0,0));
        // counter corners in IDLE
        tbl.push_back(mk(1,   0,0,1,0, 0,1,4'd2, 0,0,0,0));
        tbl.push_back(mk(1,   0,0,1,1, 0,1,4'd2, 0,0,0,0));
        tbl.push_back(mk(1,   0,0,0,1, 0,1,4'd1, 0,0,0,0));
        tbl.push_back(mk(1,   0,0,0,1, 0,1,4'd0, 0,1,0,0));
        tbl.push_back(mk(1,   0,0,0,1, 0,1,4'd0, 0,1,0,0));
        // exit request with an empty lot is never granted
        tbl.push_back(mk(3,   0,1,0,0, 0,1,4'd0, 0,1,0,0));
        // timeout: 1000 open cycles, one-cycle timeout_err, occupancy unchanged
        tbl.push_back(mk(1,   1,0,0,0, 1,1,4'd0, 0,1,1,0));
        tbl.push_back(mk(999, 0,0,0,0, 1,1,4'd0, 0,1,1,0));
        tbl.push_back(mk(1,   0,0,0,0, 0,1,4'd0, 0,1,1,1));
        tbl.push_back(mk(7,   0,0,0,0, 0,1,4'd0, 0,1,1,0));
        tbl.push_back(mk(1,   0,0,0,0, 0,1,4'd0, 0,1,0,0));
        // wrong-direction pulse while open: counts but does not close
        tbl.push_back(mk(1,   0,0,1,0, 0,1,4'd1, 0,0,0,0));
        tbl.push_back(mk(1,   1,0,0,0, 1,1,4'd1, 0,0,1,0));
        tbl.push_back(mk(1,   0,0,0,1, 1,1,4'd0, 0,1,1,0));
        tbl.push_back(mk(1,   0,0,1,0, 0,1,4'd1, 0,0,1,0));
        tbl.push_back(mk(7,   0,0,0,0, 0,1,4'd1, 0,0,1,0));
        tbl.push_back(mk(1,   0,0,0,0, 0,1,4'd1, 0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].er, tbl[i].xr, tbl[i].en, tbl[i].ex);
            for (int r = 0; r < tbl[i].reps; r++) begin
                step();
                chk($sformatf("vec%0d.%0d", i, r), 32'(outs()),
                    32'({tbl[i].go, tbl[i].di, tbl[i].occ,
                         tbl[i].fu, tbl[i].em, tbl[i].bu, tbl[i].te}));
            end
        end
        set_in(0, 0, 0, 0);

        // fill to capacity through real grants
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            set_in(1, 0, 0, 0);
            step();
            chk($sformatf("fill%0d.grant", k), 32'(bus.gate_open), 32'd1);
            set_in(0, 0, 0, 0);
            step();
            set_in(0, 0, 1, 0);
            step();
            set_in(0, 0, 0, 0);
            chk($sformatf("fill%0d.occ", k), 32'(bus.occupancy), 32'(k));
            repeat (8) step();
            chk($sformatf("fill%0d.idle", k), 32'(bus.busy), 32'd0);
        end
        chk("full.flag", 32'(bus.full), 32'd1);
        set_in(1, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("full.nogrant%0d", c), 32'(bus.gate_open), 32'd0);
        end
        set_in(1, 1, 0, 0);
        step();
        chk("full.exit_grant", 32'({bus.gate_open, bus.dir_in}), 32'b10);
        set_in(0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 1);
        step();
        set_in(0, 0, 0, 0);
        chk("full.exit_occ", 32'({bus.occupancy, bus.full}), 32'({4'd14, 1'b0}));
        repeat (8) step();
        set_in(0, 0, 1, 0);
        step();
        chk("sat.refill", 32'({bus.occupancy, bus.full}), 32'({4'd15, 1'b1}));
        step();
        set_in(0, 0, 0, 0);
        chk("sat.enter_at_cap", 32'({bus.occupancy, bus.full}), 32'({4'd15, 1'b1}));

        // round-robin with both requests held, occupancy 3
        do_reset();
        set_in(0, 0, 1, 0);
        repeat (3) step();
        set_in(0, 0, 0, 0);
        chk("rr.occ", 32'(bus.occupancy), 32'd3);
        set_in(1, 1, 0, 0);
        step();
        chk("rr.first_in", 32'({bus.gate_open, bus.dir_in}), 32'b11);
        set_in(1, 1, 1, 0);
        step();
        set_in(1, 1, 0, 0);
        chk("rr.close1", 32'({bus.gate_open, bus.occupancy}), 32'({1'b0, 4'd4}));
        repeat (8) step();
        chk("rr.idle1", 32'({bus.busy, bus.gate_open}), 32'b00);
        step();
        chk("rr.second_out", 32'({bus.gate_open, bus.dir_in}), 32'b10);
        set_in(1, 1, 0, 1);
        step();
        set_in(1, 1, 0, 0);
        chk("rr.close2", 32'({bus.gate_open, bus.occupancy}), 32'({1'b0, 4'd3}));
        repeat (8) step();
        step();
        chk("rr.third_in", 32'({bus.gate_open, bus.dir_in}), 32'b11);
        set_in(0, 0, 0, 0);

        // asynchronous reset in the middle of OPEN_OUT at occupancy 7
        do_reset();
        set_in(0, 0, 1, 0);
        repeat (7) step();
        set_in(0, 0, 0, 0);
        chk("mid.occ", 32'(bus.occupancy), 32'd7);
        set_in(0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0);
        chk("mid.open_out", 32'({bus.gate_open, bus.dir_in, bus.busy}), 32'b101);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("mid.reset", 32'(outs()), 32'(10'b0_0_0000_0_1_0_0));
        #1;
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
